led_code_sequencer: RTL and testbench

- Parametrised DIP-code-gated LED sequencer for the board LED/DIP/push-button cluster.
- A matching DIP code runs a one-shot bounce sweep across the LEDs, then routes push-buttons to the LEDs.
- Any other DIP change raises a blink alarm of configurable length.
- Runs on the system clock with an internal tick-enable; no derived clocks.

---
 rtl/led_seq_pkg.sv | 24 ++
 rtl/led_code_sequencer_tick_gen.sv | 28 ++
 rtl/led_code_sequencer.sv | 111 +++++++++++
 tb/tb_led_code_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the DIP-code-gated LED sequencer.
// Holds the sequencer state encoding and a constant-width helper.
package led_seq_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SWEEP_UP   = 3'd1,
    SWEEP_DOWN = 3'd2,
    PASS       = 3'd3,
    ALARM      = 3'd4,
    HOLD       = 3'd5
  } state_t;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/led_code_sequencer_tick_gen.sv
// Free-running divider producing a one-cycle tick enable every TICK_DIV clocks.
// The tick is an enable in the clk domain, never used as a clock.
module tick_gen
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = 13500000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + CW'(1);
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/led_code_sequencer.sv
// DIP-code-gated LED sequencer: a matching code runs a bounce sweep and then
// routes push-buttons to the LEDs; any other DIP change raises a blink alarm.
module led_code_sequencer
  import led_seq_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] CODE     = WIDTH'(4'b1001),
  parameter int               TICK_DIV = 13500000,
  parameter int               BLINKS   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dip,
  input  logic [WIDTH-1:0] pb,
  output logic [WIDTH-1:0] led,
  output logic             unlocked,
  output logic             alarm
);

  localparam int PW = clog2(2 * BLINKS);
  localparam logic [PW-1:0]    PHASE_LAST = PW'(2 * BLINKS - 1);
  localparam logic [WIDTH-1:0] LED_FIRST  = WIDTH'(1);

  logic             tick;
  state_t           state, state_d;
  logic [WIDTH-1:0] led_d;
  logic [WIDTH-1:0] dip_q;
  logic [PW-1:0]    phase, phase_d;
  logic             waiting;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // States where a new DIP value is judged against the code.
  assign waiting = (state == IDLE) || (state == ALARM) || (state == HOLD);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    led_d   = led;
    phase_d = phase;
    if (tick) begin
      if (dip == CODE && waiting) begin
        state_d = SWEEP_UP;
        led_d   = LED_FIRST;
      end else if (dip != CODE && (!waiting || dip != dip_q)) begin
        state_d = ALARM;
        phase_d = '0;
        led_d   = '1;
      end else begin
        unique case (state)
          IDLE, HOLD: led_d = '0;
          SWEEP_UP: begin
            if (led[WIDTH-1]) begin
              state_d = SWEEP_DOWN;
              led_d   = led >> 1;
            end else begin
              led_d = led << 1;
            end
          end
          SWEEP_DOWN: begin
            if (led == '0) begin
              state_d = PASS;
              led_d   = pb;
            end else begin
              led_d = led >> 1;
            end
          end
          PASS: led_d = pb;
          ALARM: begin
            if (phase == PHASE_LAST) begin
              state_d = HOLD;
              led_d   = '0;
            end else begin
              phase_d = phase + PW'(1);
              led_d   = phase_d[0] ? '0 : '1;
            end
          end
          default: begin
            state_d = IDLE;
            led_d   = '0;
          end
        endcase
      end
    end
  end

  // Flags are registered from next-state so they move with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      led      <= '0;
      phase    <= '0;
      dip_q    <= '0;
      unlocked <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      state    <= state_d;
      led      <= led_d;
      phase    <= phase_d;
      unlocked <= (state_d == PASS);
      alarm    <= (state_d == ALARM);
      if (tick) dip_q <= dip;
    end
  end

endmodule

// File: tb/tb_led_code_sequencer.sv
// Directed bench for led_code_sequencer with a 4-cycle tick, 4 LEDs, 3 blinks.
// Inputs change #1 after a clock edge; ticks land on every 4th edge after reset.
module tb_led_code_sequencer;
  import led_seq_pkg::*;

  localparam int TICK_DIV = 4;

  localparam logic [3:0] SWEEP_SEQ [8] =
    '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
  localparam logic [3:0] BLINK_SEQ [6] =
    '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dip = 4'b0000;
  logic [3:0] pb  = 4'b0000;
  logic [3:0] led;
  logic       unlocked;
  logic       alarm;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_code_sequencer #(
    .WIDTH   (4),
    .CODE    (4'b1001),
    .TICK_DIV(TICK_DIV),
    .BLINKS  (3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .dip     (dip),
    .pb      (pb),
    .led     (led),
    .unlocked(unlocked),
    .alarm   (alarm)
  );

  task automatic wait_tick();
    repeat (TICK_DIV) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    dip = 4'b0000;
    pb  = 4'b0000;
    apply_reset();
    checks++;
    if ({led, unlocked, alarm} !== 6'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL reset_state: led=%b unl=%b alm=%b state=%0d, want 0000 0 0 IDLE",
               led, unlocked, alarm, dut.state);
    end
    for (int i = 0; i < 10; i++) begin
      wait_tick();
      checks++;
      if ({led, unlocked, alarm} !== 6'b0 || dut.state !== IDLE) begin
        failures++;
        $display("FAIL idle_hold[%0d]: led=%b unl=%b alm=%b state=%0d, want 0000 0 0 IDLE",
                 i, led, unlocked, alarm, dut.state);
      end
    end
  endtask

  task automatic test_sweep();
    dip = 4'b1001;
    pb  = 4'b0110;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      wait_tick();
      checks++;
      if (led !== SWEEP_SEQ[i] || unlocked !== 1'b0 || alarm !== 1'b0) begin
        failures++;
        $display("FAIL sweep[%0d]: led=%b unl=%b alm=%b, want %b 0 0",
                 i, led, unlocked, alarm, SWEEP_SEQ[i]);
      end
    end
    wait_tick();
    checks++;
    if (led !== 4'b0110 || unlocked !== 1'b1 || dut.state !== PASS) begin
      failures++;
      $display("FAIL pass_entry: led=%b unl=%b state=%0d, want 0110 1 PASS",
               led, unlocked, dut.state);
    end
  endtask

  task automatic test_pb_ignore();
    @(posedge clk);
    #1 pb = 4'b1111;
    @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0110) begin
      failures++;
      $display("FAIL pb_between_ticks: led=%b, want 0110", led);
    end
    pb = 4'b0110;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0110) begin
      failures++;
      $display("FAIL pb_glitch_tick: led=%b, want 0110", led);
    end
    pb = 4'b0011;
    wait_tick();
    checks++;
    if (led !== 4'b0011 || unlocked !== 1'b1) begin
      failures++;
      $display("FAIL pass_follow: led=%b unl=%b, want 0011 1", led, unlocked);
    end
  endtask

  task automatic test_alarm();
    dip = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      wait_tick();
      checks++;
      if (led !== BLINK_SEQ[i] || alarm !== 1'b1 || unlocked !== 1'b0) begin
        failures++;
        $display("FAIL alarm[%0d]: led=%b alm=%b unl=%b, want %b 1 0",
                 i, led, alarm, unlocked, BLINK_SEQ[i]);
      end
    end
  endtask

  task automatic test_alarm_restart();
    dip = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      wait_tick();
      checks++;
      if (led !== BLINK_SEQ[i] || alarm !== 1'b1) begin
        failures++;
        $display("FAIL restart[%0d]: led=%b alm=%b, want %b 1",
                 i, led, alarm, BLINK_SEQ[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      wait_tick();
      checks++;
      if (led !== 4'b0000 || alarm !== 1'b0 || dut.state !== HOLD) begin
        failures++;
        $display("FAIL hold[%0d]: led=%b alm=%b state=%0d, want 0000 0 HOLD",
                 i, led, alarm, dut.state);
      end
    end
  endtask

  task automatic test_hold_to_code();
    dip = 4'b1001;
    wait_tick();
    checks++;
    if (led !== 4'b0001 || alarm !== 1'b0 || dut.state !== SWEEP_UP) begin
      failures++;
      $display("FAIL hold_to_code: led=%b alm=%b state=%0d, want 0001 0 SWEEP_UP",
               led, alarm, dut.state);
    end
  endtask

  task automatic test_reset_mid_sweep();
    wait_tick();
    wait_tick();
    checks++;
    if (led !== 4'b0100) begin
      failures++;
      $display("FAIL pre_reset_sweep: led=%b, want 0100", led);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (led !== 4'b0000 || unlocked !== 1'b0 || alarm !== 1'b0 || dut.state !== IDLE) begin
      failures++;
      $display("FAIL async_reset: led=%b unl=%b alm=%b state=%0d, want 0000 0 0 IDLE",
               led, unlocked, alarm, dut.state);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (TICK_DIV - 1) @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0000) begin
      failures++;
      $display("FAIL early_tick: led=%b after 3 cycles, want 0000", led);
    end
    @(posedge clk);
    #1;
    checks++;
    if (led !== 4'b0001 || dut.state !== SWEEP_UP) begin
      failures++;
      $display("FAIL first_tick: led=%b state=%0d at cycle 4, want 0001 SWEEP_UP",
               led, dut.state);
    end
  endtask

  task automatic test_code_during_alarm();
    dip = 4'b0100;
    wait_tick();
    checks++;
    if (led !== 4'b1111 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL sweep_abort: led=%b alm=%b, want 1111 1", led, alarm);
    end
    wait_tick();
    checks++;
    if (led !== 4'b0000 || alarm !== 1'b1) begin
      failures++;
      $display("FAIL alarm_phase1: led=%b alm=%b, want 0000 1", led, alarm);
    end
    dip = 4'b1001;
    wait_tick();
    checks++;
    if (led !== 4'b0001 || alarm !== 1'b0 || dut.state !== SWEEP_UP) begin
      failures++;
      $display("FAIL alarm_to_code: led=%b alm=%b state=%0d, want 0001 0 SWEEP_UP",
               led, alarm, dut.state);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sweep();
    test_pb_ignore();
    test_alarm();
    test_alarm_restart();
    test_hold_to_code();
    test_reset_mid_sweep();
    test_code_during_alarm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
